rgmii_rx_decoder: RTL and testbench
===================================

RGMII_RX_DECODER -- requirements
Module: rgmii_rx_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, output byte width (only 8 supported).
REQ-002 SHALL have port clk  input  1  RGMII receive clock (post-buffer), sole clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rxd_rise  input  4  RXD sampled on rising edge by input DDR capture.
REQ-005 SHALL have port rxd_fall  input  4  RXD sampled on falling edge, presented same-edge aligned with rxd_rise.
REQ-006 SHALL have port rx_ctl_rise  input  1  RX_CTL rising-edge sample.
REQ-007 SHALL have port rx_ctl_fall  input  1  RX_CTL falling-edge sample.
REQ-008 SHALL have port mii_select  input  1  1 = 10/100 nibble (SDR) mode, 0 = 1000 byte (DDR) mode.
REQ-009 SHALL have port rgmii_mac_rx_data  output  DATA_WIDTH  assembled byte to MAC receive stage.
REQ-010 SHALL have port rgmii_mac_rx_dv  output  1  byte qualifier, one cycle per valid byte.
REQ-011 SHALL have port rgmii_mac_rx_er  output  1  error flag qualified with the same byte.

Function
REQ-012 SHALL register all four capture inputs in one input stage before decode.
REQ-013 SHALL decode dv = rx_ctl_rise and er = rx_ctl_rise XOR rx_ctl_fall per RGMII.
REQ-014 SHALL latch mii_select into frame_mode on the cycle decoded dv rises; mid-frame changes take effect only after dv falls.
REQ-015 DDR mode: SHALL output data = {rxd_fall, rxd_rise}, dv, er every cycle, fixed latency 2 cycles from input to output.
REQ-016 MII mode: SHALL take one nibble per cycle from rxd_rise, ignore rxd_fall, low nibble first.
REQ-017 MII mode: SHALL run states IDLE, HUNT, LOW, HIGH.
REQ-018 IDLE -> HUNT when decoded dv=1; any state -> IDLE when dv=0.
REQ-019 HUNT: SHALL pair consecutive 0x5 nibbles and emit 0x55 with dv=1 on each completed pair.
REQ-020 HUNT: nibble 0xD immediately after 0x5 SHALL force alignment, emit 0xD5 with dv=1 (regardless of pair phase), then -> LOW.
REQ-021 HUNT: any other nibble SHALL emit that nibble zero-extended with er=1, then remain in HUNT.
REQ-022 LOW stores nibble -> HIGH; HIGH emits {nibble, stored} with dv=1 -> LOW; output er = OR of er over both nibbles.
REQ-023 MII mode: dv output SHALL be 0 on all non-emit cycles; data holds last value.
REQ-024 MII dv falling while in HIGH (odd nibble count) SHALL emit {4'h0, stored} with dv=1, er=1 in the next cycle (dribble).
REQ-025 MII latency: byte output 1 cycle after its high nibble is registered.
REQ-026 Carrier-extend/false-carrier (dv=0, er=1) SHALL not produce dv on output in either mode.

Reset
REQ-027 On reset: rgmii_mac_rx_data=0, rgmii_mac_rx_dv=0, rgmii_mac_rx_er=0, state=IDLE, input registers=0, frame_mode=mii_select-independent 0.
REQ-028 Reset mid-frame SHALL discard partial nibble and resume in IDLE; first output after release requires fresh dv rise.

Structure
REQ-029 Shared package rgmii_pkg SHALL hold state enum, PREAMBLE_NIBBLE=4'h5, SFD_NIBBLE=4'hD, SFD_BYTE=8'hD5, PREAMBLE_BYTE=8'h55.
REQ-030 SHALL be a single module, no sub-modules; input capture primitives live outside the block.

Verification
REQ-031 DDR: 7x 0x55, 0xD5, 64 payload bytes, ctl_rise=ctl_fall=1 -> identical 72 bytes out, dv=1 continuous, er=0, 2-cycle latency.
REQ-032 DDR: ctl_rise=1, ctl_fall=0 on payload byte 10 -> that byte out with er=1, others er=0.
REQ-033 MII: 15 nibbles 0x5, 0xD, payload nibbles 0x1,0x2,0x3,0x4 -> 7x 0x55, 0xD5, 0x21, 0x43, dv every second cycle.
REQ-034 MII: 14 nibbles 0x5, 0xD (even preamble) -> 0xD5 still emitted as aligned SFD, following bytes correctly paired.
REQ-035 MII: payload ending on odd nibble 0x7 -> final byte 0x07 with dv=1, er=1; mii_select toggled mid-frame -> no mode change until next frame.
REQ-036 Reset asserted mid-payload in both modes -> outputs 0 next edge, no output until next dv rise.

Source files
------------

// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - shared constants and state type for the RGMII receive decoder
package rgmii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_LOW  = 2'd2,
        ST_HIGH = 2'd3
    } rx_state_t;

    localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0] SFD_NIBBLE      = 4'hD;
    localparam logic [7:0] SFD_BYTE        = 8'hD5;
    localparam logic [7:0] PREAMBLE_BYTE   = 8'h55;

endpackage

// File: rtl/rgmii_rx_decoder.sv
// rtl/rgmii_rx_decoder.sv - RGMII receive decode to MAC byte stream (DDR byte or MII nibble mode)
module rgmii_rx_decoder
    import rgmii_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            rxd_rise,
    input  logic [3:0]            rxd_fall,
    input  logic                  rx_ctl_rise,
    input  logic                  rx_ctl_fall,
    input  logic                  mii_select,
    output logic [DATA_WIDTH-1:0] rgmii_mac_rx_data,
    output logic                  rgmii_mac_rx_dv,
    output logic                  rgmii_mac_rx_er
);

    logic [3:0] rxd_rise_q;
    logic [3:0] rxd_fall_q;
    logic       ctl_rise_q;
    logic       ctl_fall_q;

    logic       dv_prev;
    logic       frame_mode;
    rx_state_t  state;
    logic [3:0] low_nib;
    logic       low_er;
    logic       have5;
    logic       last5;

    logic       dv_dec;
    logic       er_dec;
    logic       dv_rise;
    logic       mii_mode;

    assign dv_dec   = ctl_rise_q;
    assign er_dec   = ctl_rise_q ^ ctl_fall_q;
    assign dv_rise  = dv_dec & ~dv_prev;
    // The frame's mode is sampled on the dv rise, so that first cycle must use mii_select directly.
    assign mii_mode = dv_rise ? mii_select : frame_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_rise_q        <= 4'h0;
            rxd_fall_q        <= 4'h0;
            ctl_rise_q        <= 1'b0;
            ctl_fall_q        <= 1'b0;
            dv_prev           <= 1'b0;
            frame_mode        <= 1'b0;
            state             <= ST_IDLE;
            low_nib           <= 4'h0;
            low_er            <= 1'b0;
            have5             <= 1'b0;
            last5             <= 1'b0;
            rgmii_mac_rx_data <= '0;
            rgmii_mac_rx_dv   <= 1'b0;
            rgmii_mac_rx_er   <= 1'b0;
        end else begin
            rxd_rise_q <= rxd_rise;
            rxd_fall_q <= rxd_fall;
            ctl_rise_q <= rx_ctl_rise;
            ctl_fall_q <= rx_ctl_fall;
            dv_prev    <= dv_dec;
            if (dv_rise) begin
                frame_mode <= mii_select;
            end

            rgmii_mac_rx_dv <= 1'b0;
            rgmii_mac_rx_er <= 1'b0;

            if (!mii_mode) begin
                state             <= ST_IDLE;
                have5             <= 1'b0;
                last5             <= 1'b0;
                rgmii_mac_rx_data <= DATA_WIDTH'({rxd_fall_q, rxd_rise_q});
                rgmii_mac_rx_dv   <= dv_dec;
                rgmii_mac_rx_er   <= dv_dec & er_dec;
            end else if (!dv_dec) begin
                // A frame ending on a lone low nibble still hands it to the MAC, flagged as an error.
                if (state == ST_HIGH) begin
                    rgmii_mac_rx_data <= DATA_WIDTH'({4'h0, low_nib});
                    rgmii_mac_rx_dv   <= 1'b1;
                    rgmii_mac_rx_er   <= 1'b1;
                end
                state <= ST_IDLE;
                have5 <= 1'b0;
                last5 <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_HUNT: begin
                        state <= ST_HUNT;
                        if (rxd_rise_q == PREAMBLE_NIBBLE) begin
                            last5 <= 1'b1;
                            have5 <= ~have5;
                            if (have5) begin
                                rgmii_mac_rx_data <= DATA_WIDTH'(PREAMBLE_BYTE);
                                rgmii_mac_rx_dv   <= 1'b1;
                                rgmii_mac_rx_er   <= er_dec;
                            end
                        end else if (rxd_rise_q == SFD_NIBBLE && last5) begin
                            // SFD realigns byte phase even after an odd-length preamble.
                            state             <= ST_LOW;
                            have5             <= 1'b0;
                            last5             <= 1'b0;
                            rgmii_mac_rx_data <= DATA_WIDTH'(SFD_BYTE);
                            rgmii_mac_rx_dv   <= 1'b1;
                            rgmii_mac_rx_er   <= er_dec;
                        end else begin
                            have5             <= 1'b0;
                            last5             <= 1'b0;
                            rgmii_mac_rx_data <= DATA_WIDTH'({4'h0, rxd_rise_q});
                            rgmii_mac_rx_dv   <= 1'b1;
                            rgmii_mac_rx_er   <= 1'b1;
                        end
                    end
                    ST_LOW: begin
                        low_nib <= rxd_rise_q;
                        low_er  <= er_dec;
                        state   <= ST_HIGH;
                    end
                    ST_HIGH: begin
                        rgmii_mac_rx_data <= DATA_WIDTH'({rxd_rise_q, low_nib});
                        rgmii_mac_rx_dv   <= 1'b1;
                        rgmii_mac_rx_er   <= low_er | er_dec;
                        state             <= ST_LOW;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// tb/tb_rgmii_rx_decoder.sv - scoreboard bench for rgmii_rx_decoder with a frame-level reference model
module tb_rgmii_rx_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rxd_rise = 4'h0;
    logic [3:0] rxd_fall = 4'h0;
    logic       rx_ctl_rise = 1'b0;
    logic       rx_ctl_fall = 1'b0;
    logic       mii_select = 1'b0;
    logic [7:0] rgmii_mac_rx_data;
    logic       rgmii_mac_rx_dv;
    logic       rgmii_mac_rx_er;

    rgmii_rx_decoder #(.DATA_WIDTH(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .rxd_rise          (rxd_rise),
        .rxd_fall          (rxd_fall),
        .rx_ctl_rise       (rx_ctl_rise),
        .rx_ctl_fall       (rx_ctl_fall),
        .mii_select        (mii_select),
        .rgmii_mac_rx_data (rgmii_mac_rx_data),
        .rgmii_mac_rx_dv   (rgmii_mac_rx_dv),
        .rgmii_mac_rx_er   (rgmii_mac_rx_er)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       er;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         stamp = 0;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] nq[$];
    logic [7:0] bq[$];
    logic       eq[$];

    always @(posedge clk) cyc++;

    // Every emitted byte must match the head of the queue in value, error flag and arrival cycle.
    always @(negedge clk) begin
        if (!reset && rgmii_mac_rx_dv) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got data=%h er=%b at cycle %0d, required no output",
                         rgmii_mac_rx_data, rgmii_mac_rx_er, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rgmii_mac_rx_data !== e.data || rgmii_mac_rx_er !== e.er || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL byte: got data=%h er=%b cycle=%0d, required data=%h er=%b cycle=%0d",
                             rgmii_mac_rx_data, rgmii_mac_rx_er, cyc, e.data, e.er, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] f, input logic cr, input logic cf);
        @(negedge clk);
        rxd_rise    = r;
        rxd_fall    = f;
        rx_ctl_rise = cr;
        rx_ctl_fall = cf;
        stamp       = cyc;
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic e);
        exp_q.push_back('{d, e, stamp + 2});
    endtask

    task automatic gap(input int n);
        repeat (n) drive(4'($urandom), 4'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        reset       = 1'b1;
        rx_ctl_rise = 1'b0;
        rx_ctl_fall = 1'b0;
        #1;
        chk({tag, "_data"}, rgmii_mac_rx_data, 8'h00);
        chk({tag, "_dv"}, {7'h0, rgmii_mac_rx_dv}, 8'h00);
        chk({tag, "_er"}, {7'h0, rgmii_mac_rx_er}, 8'h00);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        gap(4);
    endtask

    // Byte-wide frame from bq/eq: each byte reappears two cycles later, error where ctl_fall was low.
    task automatic ddr_frame(input int toggle_at, input int stop_at);
        for (int i = 0; i < bq.size(); i++) begin
            if (i == stop_at) begin
                reset_pulse("ddr_reset");
                return;
            end
            if (i == toggle_at) mii_select = ~mii_select;
            drive(bq[i][3:0], bq[i][7:4], 1'b1, ~eq[i]);
            expect_byte(bq[i], eq[i]);
        end
        gap(3);
    endtask

    // Nibble frame from nq: preamble run pairs to 0x55, 0xD after a 5 aligns, payload pairs low-first.
    task automatic mii_frame(input int toggle_at, input int stop_at);
        int         run;
        int         p;
        bit         payload;
        logic [3:0] prev;
        run = 0;
        p = 0;
        payload = 1'b0;
        prev = 4'h0;
        for (int i = 0; i < nq.size(); i++) begin
            if (i == stop_at) begin
                reset_pulse("mii_reset");
                return;
            end
            if (i == toggle_at) mii_select = ~mii_select;
            drive(nq[i], 4'($urandom), 1'b1, 1'b1);
            if (!payload) begin
                if (nq[i] == 4'h5) begin
                    run++;
                    if (run % 2 == 0) expect_byte(8'h55, 1'b0);
                end else if (nq[i] == 4'hD && run > 0) begin
                    expect_byte(8'hD5, 1'b0);
                    payload = 1'b1;
                end else begin
                    expect_byte({4'h0, nq[i]}, 1'b1);
                    run = 0;
                end
            end else begin
                if (p % 2 == 1) expect_byte({nq[i], prev}, 1'b0);
                prev = nq[i];
                p++;
            end
        end
        drive(4'($urandom), 4'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        if (payload && p % 2 == 1) expect_byte({4'h0, prev}, 1'b1);
        gap(3);
    endtask

    task automatic load_preamble(input int n5);
        nq.delete();
        repeat (n5) nq.push_back(4'h5);
        nq.push_back(4'hD);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_data", rgmii_mac_rx_data, 8'h00);
        chk("reset_dv", {7'h0, rgmii_mac_rx_dv}, 8'h00);
        chk("reset_er", {7'h0, rgmii_mac_rx_er}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        gap(4);

        // DDR: preamble, SFD, 64 payload bytes, clean then with an error on payload byte 10
        for (int pass = 0; pass < 2; pass++) begin
            mii_select = 1'b0;
            bq.delete();
            eq.delete();
            repeat (7) begin bq.push_back(8'h55); eq.push_back(1'b0); end
            bq.push_back(8'hD5); eq.push_back(1'b0);
            for (int i = 0; i < 64; i++) begin
                bq.push_back(8'($urandom));
                eq.push_back(pass == 1 && i == 10);
            end
            ddr_frame(-1, -1);
        end

        // MII: odd and even preambles with a short payload
        mii_select = 1'b1;
        load_preamble(15);
        nq.push_back(4'h1); nq.push_back(4'h2); nq.push_back(4'h3); nq.push_back(4'h4);
        mii_frame(-1, -1);
        load_preamble(14);
        nq.push_back(4'hA); nq.push_back(4'hB); nq.push_back(4'hC); nq.push_back(4'hD);
        mii_frame(-1, -1);

        // MII: odd payload ending on 7 with mii_select dropped mid-frame; next frame is DDR
        load_preamble(15);
        nq.push_back(4'h1); nq.push_back(4'h2); nq.push_back(4'h7);
        mii_frame(17, -1);
        bq.delete(); eq.delete();
        for (int i = 0; i < 8; i++) begin bq.push_back(8'($urandom)); eq.push_back(1'b0); end
        ddr_frame(4, -1);

        // MII hunt with a stray nibble, then SFD right after a single 5
        nq.delete();
        nq.push_back(4'h5); nq.push_back(4'h5); nq.push_back(4'h3);
        nq.push_back(4'h5); nq.push_back(4'hD);
        nq.push_back(4'h6); nq.push_back(4'h9);
        mii_frame(-1, -1);

        // Reset mid-payload in both modes, then a fresh frame must decode normally
        mii_select = 1'b1;
        load_preamble(15);
        for (int i = 0; i < 10; i++) nq.push_back(4'($urandom));
        mii_frame(-1, 21);
        mii_frame(-1, -1);
        mii_select = 1'b0;
        bq.delete(); eq.delete();
        for (int i = 0; i < 20; i++) begin bq.push_back(8'($urandom)); eq.push_back(1'b0); end
        ddr_frame(-1, 12);
        ddr_frame(-1, -1);

        // Random frames in both modes
        for (int f = 0; f < 24; f++) begin
            mii_select = 1'($urandom_range(0, 1));
            if (mii_select) begin
                nq.delete();
                repeat ($urandom_range(1, 16)) begin
                    if ($urandom_range(0, 9) == 0) nq.push_back(4'($urandom));
                    else nq.push_back(4'h5);
                end
                nq.push_back(4'hD);
                repeat ($urandom_range(0, 21)) nq.push_back(4'($urandom));
                mii_frame(-1, -1);
            end else begin
                bq.delete(); eq.delete();
                repeat ($urandom_range(1, 40)) begin
                    bq.push_back(8'($urandom));
                    eq.push_back($urandom_range(0, 9) == 0);
                end
                ddr_frame(-1, -1);
            end
        end

        gap(6);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_bytes: %0d expected bytes never appeared, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
